// File: rtl/pb_cond_pkg.sv
// Purpose: shared types and defaults for the pushbutton debounce block.
// Latency: n/a (declarations only).
// Backpressure: n/a; keys are free-running levels with no flow control.
package pb_cond_pkg;

    // Per-channel debounce states: two stable states, each with a qualifying shadow.
    typedef enum logic [1:0] {
        REL     = 2'd0,
        CHK_PRS = 2'd1,
        PRS     = 2'd2,
        CHK_REL = 2'd3
    } deb_state_t;

    // 10 ms hold time at a 50 MHz clock.
    localparam int DEFAULT_CNT_MAX = 500_000;

endpackage

// File: rtl/key_debounce_ch.sv
// Purpose: one key channel: 2-flop synchroniser, stability counter, debounce FSM, pulse flops.
// Latency: an accepted level reaches key_n_out and a pulse CNT_MAX+1 edges after sync1 captures it.
// Backpressure: none; the channel samples every cycle and outputs are plain flop levels/strobes.
module key_debounce_ch
    import pb_cond_pkg::*;
#(
    parameter int CNT_MAX = DEFAULT_CNT_MAX,
    parameter int CNT_W   = $clog2(CNT_MAX + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n_in,
    output logic key_n_out,
    output logic press_pulse,
    output logic release_pulse
);

    // Terminal count: the CHK state is left here, so the counter never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             key_q,   key_d;
    logic             press_q, press_d;
    logic             rel_q,   rel_d;

    // Synchroniser inputs: raw pin into sync1, sync1 into sync2.
    always_comb begin
        sync1_d = key_n_in;
        sync2_d = sync1_q;
    end

    // Next-state: qualify a new sync2 level for CNT_MAX cycles; any bounce
    // drops straight back to the stable state with the count cleared.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            REL: begin
                if (!sync2_q) begin
                    state_d = CHK_PRS;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_PRS: begin
                if (sync2_q) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRS;
                    key_d   = 1'b0;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRS: begin
                if (sync2_q) begin
                    state_d = CHK_REL;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_REL: begin
                if (!sync2_q) begin
                    state_d = PRS;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = REL;
                    key_d   = 1'b1;
                    rel_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
                key_d   = 1'b1;
            end
        endcase
    end

    // State register; reset forces the released condition with no pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= REL;
            cnt_q   <= '0;
            key_q   <= 1'b1;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign key_n_out     = key_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;

endmodule

// File: rtl/pushbutton_conditioner.sv
// Purpose: debounces NUM_KEYS raw active-low keys into clean levels plus press/release strobes.
// Latency: CNT_MAX+1 edges from sync1 capture of a stable level to output update.
// Backpressure: none; every channel runs independently every cycle.
module pushbutton_conditioner
    import pb_cond_pkg::*;
#(
    parameter int NUM_KEYS = 4,
    parameter int CNT_MAX  = DEFAULT_CNT_MAX,
    parameter int CNT_W    = $clog2(CNT_MAX + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n_in,
    output logic [NUM_KEYS-1:0] key_n_out,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse
);

    // One fully independent debounce channel per key.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .CNT_MAX (CNT_MAX),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk           (clk),
            .reset_n       (reset_n),
            .key_n_in      (key_n_in[i]),
            .key_n_out     (key_n_out[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule
